// File: rtl/kbd_scan_decoder_if.sv
// Purpose: bundles the FIFO-side byte handshake and the display-side key outputs of kbd_scan_decoder.
// Latency: wires only, no storage.
// Backpressure: the decoder pops a byte by pulsing nextdata_n low; the FIFO head is held while ready=1.
interface kbd_scan_decoder_if;
    // FIFO head byte and non-empty flag
    logic [7:0] ps2_data;
    logic       ready;
    // active-low one-cycle pop strobe back to the FIFO
    logic       nextdata_n;
    // held-key outputs toward the seven-segment stage
    logic [7:0] data;
    logic [7:0] de_code;
    logic [7:0] counter;
    logic       key_valid;

    // FIFO / stimulus side
    modport master (
        output ps2_data,
        output ready,
        input  nextdata_n,
        input  data,
        input  de_code,
        input  counter,
        input  key_valid
    );

    // decoder side
    modport slave (
        input  ps2_data,
        input  ready,
        output nextdata_n,
        output data,
        output de_code,
        output counter,
        output key_valid
    );
endinterface

// File: rtl/kbd_scan_decoder.sv
// Purpose: turns PS/2 set-2 scan bytes into held-key code, ASCII and press count (BCD count when KBD_BCD_COUNT_EN is defined).
// Latency: byte captured at edge E, outputs updated at edge E+1; one byte per two cycles.
// Backpressure: pops only when ready=1 and the FSM is idle; the FIFO simply waits otherwise.
module kbd_scan_decoder #(
    parameter int IGNORE_REPEAT = 1,
    parameter int ASCII_UPPER   = 0
) (
    input  logic               clk,
    input  logic               clrn,
    kbd_scan_decoder_if.slave  kbd
);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic {
        IDLE = 1'b0,
        PROC = 1'b1
    } state_t;

    state_t     state;
    logic       nextdata_n_r;
    logic [7:0] byte_r;
    logic       brk_flag;
    logic       ext_flag;
    logic [7:0] data_r;
    logic [7:0] de_code_r;
    logic [7:0] counter_r;
    logic       key_valid_r;

    logic [7:0] ascii_lc;
    logic [7:0] ascii;
    logic       key_is_new;
    logic       count_en;
    logic [7:0] counter_inc;

    // Next counter value: two packed decimal digits or plain binary, both wrapping.
    function automatic logic [7:0] count_next(input logic [7:0] c);
`ifdef KBD_BCD_COUNT_EN
        if (c[3:0] >= 4'd9) begin
            if (c[7:4] >= 4'd9) begin
                return 8'h00;
            end
            return {c[7:4] + 4'd1, 4'd0};
        end
        return {c[7:4], c[3:0] + 4'd1};
`else
        return c + 8'd1;
`endif
    endfunction

    // Set-2 code to ASCII, letters in lowercase form; anything unknown maps to 0x00.
    always_comb begin
        ascii_lc = 8'h00;
        case (byte_r)
            8'h1C: ascii_lc = 8'h61; // a
            8'h32: ascii_lc = 8'h62; // b
            8'h21: ascii_lc = 8'h63; // c
            8'h23: ascii_lc = 8'h64; // d
            8'h24: ascii_lc = 8'h65; // e
            8'h2B: ascii_lc = 8'h66; // f
            8'h34: ascii_lc = 8'h67; // g
            8'h33: ascii_lc = 8'h68; // h
            8'h43: ascii_lc = 8'h69; // i
            8'h3B: ascii_lc = 8'h6A; // j
            8'h42: ascii_lc = 8'h6B; // k
            8'h4B: ascii_lc = 8'h6C; // l
            8'h3A: ascii_lc = 8'h6D; // m
            8'h31: ascii_lc = 8'h6E; // n
            8'h44: ascii_lc = 8'h6F; // o
            8'h4D: ascii_lc = 8'h70; // p
            8'h15: ascii_lc = 8'h71; // q
            8'h2D: ascii_lc = 8'h72; // r
            8'h1B: ascii_lc = 8'h73; // s
            8'h2C: ascii_lc = 8'h74; // t
            8'h3C: ascii_lc = 8'h75; // u
            8'h2A: ascii_lc = 8'h76; // v
            8'h1D: ascii_lc = 8'h77; // w
            8'h22: ascii_lc = 8'h78; // x
            8'h35: ascii_lc = 8'h79; // y
            8'h1A: ascii_lc = 8'h7A; // z
            8'h45: ascii_lc = 8'h30; // 0
            8'h16: ascii_lc = 8'h31; // 1
            8'h1E: ascii_lc = 8'h32; // 2
            8'h26: ascii_lc = 8'h33; // 3
            8'h25: ascii_lc = 8'h34; // 4
            8'h2E: ascii_lc = 8'h35; // 5
            8'h36: ascii_lc = 8'h36; // 6
            8'h3D: ascii_lc = 8'h37; // 7
            8'h3E: ascii_lc = 8'h38; // 8
            8'h46: ascii_lc = 8'h39; // 9
            8'h29: ascii_lc = 8'h20; // space
            8'h5A: ascii_lc = 8'h0D; // enter -> CR
            default: ascii_lc = 8'h00;
        endcase
    end

    // Fold letters to uppercase when configured; digits and controls pass through.
    always_comb begin
        ascii = ascii_lc;
        if ((ASCII_UPPER != 0) && (ascii_lc >= 8'h61) && (ascii_lc <= 8'h7A)) begin
            ascii = ascii_lc - 8'h20;
        end
    end

    // A make is a new press unless it repeats the code already held (typematic).
    always_comb begin
        key_is_new  = !key_valid_r || (byte_r != data_r);
        count_en    = key_is_new || (IGNORE_REPEAT == 0);
        counter_inc = count_next(counter_r);
    end

    // Two-state pop/process FSM with the prefix flags and all registered outputs.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state        <= IDLE;
            nextdata_n_r <= 1'b1;
            byte_r       <= 8'h00;
            brk_flag     <= 1'b0;
            ext_flag     <= 1'b0;
            data_r       <= 8'h00;
            de_code_r    <= 8'h00;
            counter_r    <= 8'h00;
            key_valid_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    nextdata_n_r <= 1'b1;
                    if (kbd.ready) begin
                        byte_r       <= kbd.ps2_data;
                        nextdata_n_r <= 1'b0;
                        state        <= PROC;
                    end
                end
                PROC: begin
                    // the pop strobe is exactly one cycle; ready is not looked at here
                    nextdata_n_r <= 1'b1;
                    state        <= IDLE;
                    if (byte_r == CODE_EXT) begin
                        ext_flag <= 1'b1;
                    end else if (byte_r == CODE_BRK) begin
                        brk_flag <= 1'b1;
                    end else if (brk_flag) begin
                        // release only clears the display if it names the held key
                        if ((byte_r == data_r) && key_valid_r) begin
                            data_r      <= 8'h00;
                            de_code_r   <= 8'h00;
                            key_valid_r <= 1'b0;
                        end
                        brk_flag <= 1'b0;
                        ext_flag <= 1'b0;
                    end else begin
                        // make: latest key replaces whatever was held
                        data_r      <= byte_r;
                        key_valid_r <= 1'b1;
                        de_code_r   <= ext_flag ? 8'h00 : ascii;
                        if (count_en) begin
                            counter_r <= counter_inc;
                        end
                        ext_flag <= 1'b0;
                    end
                end
                default: begin
                    nextdata_n_r <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign kbd.nextdata_n = nextdata_n_r;
    assign kbd.data       = data_r;
    assign kbd.de_code    = de_code_r;
    assign kbd.counter    = counter_r;
    assign kbd.key_valid  = key_valid_r;

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Purpose: directed, table-driven check of kbd_scan_decoder with a behavioural PS/2 FIFO model.
// Latency: expects outputs one edge after the pop edge; pops spaced two cycles in a burst.
// Backpressure: FIFO model holds its head until it sees nextdata_n low.
module tb_kbd_scan_decoder;

    logic clk;
    logic clrn;

    kbd_scan_decoder_if u_if0();
    kbd_scan_decoder_if u_if1();

    // dut0: defaults (repeats ignored, lowercase); dut1: every make counted, uppercase
    kbd_scan_decoder #(.IGNORE_REPEAT(1), .ASCII_UPPER(0)) u_dut0 (
        .clk  (clk),
        .clrn (clrn),
        .kbd  (u_if0.slave)
    );

    kbd_scan_decoder #(.IGNORE_REPEAT(0), .ASCII_UPPER(1)) u_dut1 (
        .clk  (clk),
        .clrn (clrn),
        .kbd  (u_if1.slave)
    );

    // dut1 sees the same FIFO; its FSM runs in lockstep with dut0
    assign u_if1.ps2_data = u_if0.ps2_data;
    assign u_if1.ready    = u_if0.ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] fifo[$];
    int         pop_cyc[$];
    int         cyc;
    int         dbl_low;
    logic       prev_low;

    int n_chk;
    int n_fail;

    // FIFO model: pops on an observed low strobe, counts strobes held low two cycles
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (u_if0.nextdata_n === 1'b0) begin
            if (prev_low) dbl_low = dbl_low + 1;
            pop_cyc.push_back(cyc);
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        prev_low = (u_if0.nextdata_n === 1'b0);
        u_if0.ready    = (fifo.size() > 0);
        u_if0.ps2_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end

    typedef struct {
        logic [7:0] code;
        logic [7:0] e_data;
        logic [7:0] e_de;
        logic [7:0] e_de1;
        logic       e_kv;
        int         e_c0;
        int         e_c1;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [7:0] code, input logic [7:0] d, input logic [7:0] de,
                                input logic [7:0] de1, input logic kv, input int c0, input int c1);
        vec_t v;
        v.code = code; v.e_data = d; v.e_de = de; v.e_de1 = de1;
        v.e_kv = kv; v.e_c0 = c0; v.e_c1 = c1;
        return v;
    endfunction

    // expected counter encoding for n presses since reset
    function automatic logic [7:0] enc(input int n);
`ifdef KBD_BCD_COUNT_EN
        int m;
        m = n % 100;
        return {4'(m / 10), 4'(m % 10)};
`else
        return 8'(n % 256);
`endif
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // wait for the next pop (optionally queueing a byte first), then step to the processing edge
    task automatic proc(input logic [7:0] b, input bit do_push);
        int  p0;
        bit  seen;
        p0   = pop_cyc.size();
        seen = 1'b0;
        if (do_push) fifo.push_back(b);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (pop_cyc.size() > p0) seen = 1'b1;
        end
        if (!seen) begin
            n_chk  = n_chk + 1;
            n_fail = n_fail + 1;
            $display("FAIL pop_timeout: got no pop expected pop of 0x%02h", b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] d, input logic [7:0] de,
                           input logic [7:0] de1, input logic kv, input int c0, input int c1);
        chk({tag, ".data"},     u_if0.data,             d);
        chk({tag, ".de_code"},  u_if0.de_code,          de);
        chk({tag, ".key_valid"},{7'd0, u_if0.key_valid},{7'd0, kv});
        chk({tag, ".counter"},  u_if0.counter,          enc(c0));
        chk({tag, ".de_code1"}, u_if1.de_code,          de1);
        chk({tag, ".counter1"}, u_if1.counter,          enc(c1));
    endtask

    initial begin
        logic [7:0] wcode[16];
        int         p0;
        int         npairs;
        bit         done;

        n_chk = 0; n_fail = 0; cyc = 0; dbl_low = 0; prev_low = 1'b0;
        u_if0.ready = 1'b0; u_if0.ps2_data = 8'h00;
        clrn = 1'b0;

        // reset held three cycles with a byte waiting: no pop may be issued
        fifo.push_back(8'h29);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst_nextdata_n%0d", i), {7'd0, u_if0.nextdata_n}, 8'h01);
        end
        chk("rst_data",      u_if0.data,               8'h00);
        chk("rst_de_code",   u_if0.de_code,            8'h00);
        chk("rst_counter",   u_if0.counter,            8'h00);
        chk("rst_key_valid", {7'd0, u_if0.key_valid},  8'h00);
        chk("rst_fifo_kept", 8'(fifo.size()),          8'h01);
        clrn = 1'b1;

        proc(8'h29, 1'b0);
        chk_all("space", 8'h29, 8'h20, 8'h20, 1'b1, 1, 1);

        // code, data, de_code, de_code(upper), key_valid, presses dut0, presses dut1
        vt.push_back(mk(8'hF0, 8'h29, 8'h20, 8'h20, 1'b1, 1, 1));
        vt.push_back(mk(8'h29, 8'h00, 8'h00, 8'h00, 1'b0, 1, 1));
        vt.push_back(mk(8'h1C, 8'h1C, 8'h61, 8'h41, 1'b1, 2, 2));
        vt.push_back(mk(8'hF0, 8'h1C, 8'h61, 8'h41, 1'b1, 2, 2));
        vt.push_back(mk(8'h1C, 8'h00, 8'h00, 8'h00, 1'b0, 2, 2));
        vt.push_back(mk(8'h1C, 8'h1C, 8'h61, 8'h41, 1'b1, 3, 3));
        vt.push_back(mk(8'h1C, 8'h1C, 8'h61, 8'h41, 1'b1, 3, 4));
        vt.push_back(mk(8'h1C, 8'h1C, 8'h61, 8'h41, 1'b1, 3, 5));
        vt.push_back(mk(8'hF0, 8'h1C, 8'h61, 8'h41, 1'b1, 3, 5));
        vt.push_back(mk(8'h1C, 8'h00, 8'h00, 8'h00, 1'b0, 3, 5));
        vt.push_back(mk(8'hE0, 8'h00, 8'h00, 8'h00, 1'b0, 3, 5));
        vt.push_back(mk(8'h75, 8'h75, 8'h00, 8'h00, 1'b1, 4, 6));
        vt.push_back(mk(8'hE0, 8'h75, 8'h00, 8'h00, 1'b1, 4, 6));
        vt.push_back(mk(8'hF0, 8'h75, 8'h00, 8'h00, 1'b1, 4, 6));
        vt.push_back(mk(8'h75, 8'h00, 8'h00, 8'h00, 1'b0, 4, 6));
        vt.push_back(mk(8'hE0, 8'h00, 8'h00, 8'h00, 1'b0, 4, 6));
        vt.push_back(mk(8'hF0, 8'h00, 8'h00, 8'h00, 1'b0, 4, 6));
        vt.push_back(mk(8'h1C, 8'h00, 8'h00, 8'h00, 1'b0, 4, 6));
        vt.push_back(mk(8'h1C, 8'h1C, 8'h61, 8'h41, 1'b1, 5, 7));
        vt.push_back(mk(8'hF0, 8'h1C, 8'h61, 8'h41, 1'b1, 5, 7));
        vt.push_back(mk(8'h1C, 8'h00, 8'h00, 8'h00, 1'b0, 5, 7));
        vt.push_back(mk(8'h45, 8'h45, 8'h30, 8'h30, 1'b1, 6, 8));
        vt.push_back(mk(8'h16, 8'h16, 8'h31, 8'h31, 1'b1, 7, 9));
        vt.push_back(mk(8'hF0, 8'h16, 8'h31, 8'h31, 1'b1, 7, 9));
        vt.push_back(mk(8'h45, 8'h16, 8'h31, 8'h31, 1'b1, 7, 9));
        vt.push_back(mk(8'hF0, 8'h16, 8'h31, 8'h31, 1'b1, 7, 9));
        vt.push_back(mk(8'h16, 8'h00, 8'h00, 8'h00, 1'b0, 7, 9));
        vt.push_back(mk(8'h5A, 8'h5A, 8'h0D, 8'h0D, 1'b1, 8, 10));
        vt.push_back(mk(8'hF0, 8'h5A, 8'h0D, 8'h0D, 1'b1, 8, 10));
        vt.push_back(mk(8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, 8, 10));
        vt.push_back(mk(8'h1A, 8'h1A, 8'h7A, 8'h5A, 1'b1, 9, 11));
        vt.push_back(mk(8'hF0, 8'h1A, 8'h7A, 8'h5A, 1'b1, 9, 11));
        vt.push_back(mk(8'h1A, 8'h00, 8'h00, 8'h00, 1'b0, 9, 11));
        vt.push_back(mk(8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 10, 12));
        vt.push_back(mk(8'hF0, 8'h05, 8'h00, 8'h00, 1'b1, 10, 12));
        vt.push_back(mk(8'h05, 8'h00, 8'h00, 8'h00, 1'b0, 10, 12));

        foreach (vt[i]) begin
            proc(vt[i].code, 1'b1);
            chk_all($sformatf("vec%0d_%02h", i, vt[i].code), vt[i].e_data, vt[i].e_de,
                    vt[i].e_de1, vt[i].e_kv, vt[i].e_c0, vt[i].e_c1);
        end

        // back-to-back burst: pops must come every two cycles
        p0 = pop_cyc.size();
        fifo.push_back(8'h1C); fifo.push_back(8'hF0); fifo.push_back(8'h1C);
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            #1;
            if (pop_cyc.size() >= p0 + 3) done = 1'b1;
        end
        chk("burst_pops", 8'(pop_cyc.size() - p0), 8'd3);
        @(posedge clk);
        #1;
        if (done) begin
            chk("burst_gap1", 8'(pop_cyc[p0 + 1] - pop_cyc[p0]),     8'd2);
            chk("burst_gap2", 8'(pop_cyc[p0 + 2] - pop_cyc[p0 + 1]), 8'd2);
        end
        chk_all("burst", 8'h00, 8'h00, 8'h00, 1'b0, 11, 13);

        // reset lands on the processing edge of 0x2B; 0x1C behind it must stay queued
        p0 = pop_cyc.size();
        fifo.push_back(8'h2B); fifo.push_back(8'h1C);
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            #1;
            if (pop_cyc.size() > p0) done = 1'b1;
        end
        clrn = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_nextdata_n", {7'd0, u_if0.nextdata_n}, 8'h01);
        chk("midrst_data",       u_if0.data,               8'h00);
        chk("midrst_counter",    u_if0.counter,            8'h00);
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("midrst_pops",  8'(pop_cyc.size() - p0), 8'd1);
        chk("midrst_fifo",  8'(fifo.size()),          8'd1);
        clrn = 1'b1;
        proc(8'h1C, 1'b0);
        chk_all("after_rst", 8'h1C, 8'h61, 8'h41, 1'b1, 1, 1);

        // clean reset, then count distinct presses up to and past the wrap
        clrn = 1'b0;
        @(posedge clk); @(posedge clk);
        #1;
        clrn = 1'b1;
        wcode = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                  8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D};
`ifdef KBD_BCD_COUNT_EN
        npairs = 100;
`else
        npairs = 256;
`endif
        for (int k = 1; k <= npairs; k++) begin
            proc(wcode[k % 16], 1'b1);
            proc(8'hF0, 1'b1);
            proc(wcode[k % 16], 1'b1);
            if (k == 10 || k == npairs - 1 || k == npairs) begin
                chk($sformatf("wrap%0d_counter", k),  u_if0.counter, enc(k));
                chk($sformatf("wrap%0d_counter1", k), u_if1.counter, enc(k));
            end
        end
`ifdef KBD_BCD_COUNT_EN
        chk("wrap_end_bcd", u_if0.counter, 8'h00);
`else
        chk("wrap_end_bin", u_if0.counter, 8'h00);
`endif

        chk("strobe_single_cycle", 8'(dbl_low), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/kbd_scan_decoder.md
Name: kbd_scan_decoder

Overview:
- Upstream stage of the PS/2 display path. Pops raw set-2 scan-code bytes from the PS/2 receiver FIFO.
- Tracks make/break/extended prefixes and keeps the code of the key currently held.
- Registers that code, its ASCII translation and a key-press count, for the seven-segment display stage.

Parameters:
IGNORE_REPEAT, 1, 1: typematic repeats of the held key are not counted; 0: every make code is counted
ASCII_UPPER, 0, 1: letters translate to uppercase (0x41-0x5A); 0: lowercase (0x61-0x7A)

Ports:
clk  input  1  system clock
clrn  input  1  synchronous active-low reset
ps2_data  input  8  byte at FIFO head, valid while ready=1
ready  input  1  FIFO non-empty
nextdata_n  output  1  active-low pop strobe to FIFO; low for exactly one cycle per byte consumed
data  output  8  scan code of held key; 0x00 when none
de_code  output  8  ASCII of held key; 0x00 when none, extended or untranslatable
counter  output  8  number of key presses
key_valid  output  1  1 while a key is held; display stage blanks when 0

Behaviour:
- One clock domain, clk. Reset is synchronous and active-low, on clrn.
- Reset, sampled on clk while clrn=0: state=IDLE, nextdata_n=1, data=0x00, de_code=0x00, counter=0x00, key_valid=0, brk_flag=0, ext_flag=0, byte_r=0x00.
- Reset mid-operation aborts everything. A byte captured but not yet processed is discarded. If nextdata_n was low, it returns to 1 at that same edge, so no second pop is issued.
- FSM state IDLE: when ready=1 at edge E, byte_r<=ps2_data, nextdata_n<=0, state<=PROC. When ready=0, hold.
- FSM state PROC: at edge E+1, nextdata_n<=1, byte_r is processed, state<=IDLE. ready is ignored in PROC.
- Throughput: 1 byte per 2 cycles. Outputs reflect a byte after edge E+1.
- Byte 0xE0: ext_flag<=1. No output change.
- Byte 0xF0: brk_flag<=1. No output change.
- Any other byte, brk_flag=1 (release):
  - If byte_r==data and key_valid=1: data<=0x00, de_code<=0x00, key_valid<=0.
  - Otherwise: no output change.
  - In both cases brk_flag<=0, ext_flag<=0.
- Any other byte, brk_flag=0 (make). Let new = (key_valid=0 or byte_r!=data).
  - data<=byte_r and key_valid<=1.
  - de_code<=0x00 if ext_flag=1, else the table value.
  - counter increments when new=1, or always when IGNORE_REPEAT=0.
  - ext_flag<=0.
- Counter arithmetic: 8-bit binary, wraps 0xFF->0x00.
- Only one key is tracked. A make of a different key while one is held replaces it and counts as new.
- ASCII table, combinational on byte_r and registered with data:
  - Letters, lowercase form: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - Others: 29 space 0x20, 5A CR 0x0D.
  - Any other code: 0x00.
- Simultaneous events: a clrn=0 edge overrides all. ready rising during PROC is not acted on until IDLE.

Optional Feature:
- Macro KBD_BCD_COUNT_EN.
- Defined: counter is two BCD digits, 0x00..0x99. Increment 0x09->0x10, wrap 0x99->0x00. Nibbles never exceed 9.
- Not defined: 8-bit binary counter, as in Behaviour.

Test Plan:
- Reset: hold clrn=0 for 3 cycles with ready=1 -> nextdata_n=1 throughout; all outputs 0.
- FIFO bytes 1C,F0,1C -> after 1C: data=0x1C, de_code=0x61, key_valid=1, counter=0x01. After F0,1C: data=0x00, de_code=0x00, key_valid=0, counter=0x01. Exactly 3 single-cycle nextdata_n pulses, spaced 2 cycles apart.
- Typematic: bytes 1C,1C,1C,F0,1C with IGNORE_REPEAT=1 -> counter=0x01; with IGNORE_REPEAT=0 -> counter=0x03.
- Extended: bytes E0,75,E0,F0,75 -> data=0x75, de_code=0x00, key_valid=1, counter+1; then release -> key_valid=0, ext_flag cleared.
- Wrap: 256 distinct press/release pairs of 16 -> counter returns to 0x00 in binary mode. With KBD_BCD_COUNT_EN, 100 pairs -> 0x99 then 0x00, and 10 pairs -> 0x10.
- Reset mid-operation: clrn=0 in the PROC cycle of byte 2B -> data stays 0x00, nextdata_n=1 at that edge; FIFO head is popped only once.
